fetch_queue: RTL

- Instruction queue between the fetch unit (PC/IM) and the decode/control stage.
- Buffers {pc, instruction} pairs from fetch with a valid/ready handshake on both sides.
- Lets decode stall without losing fetched words; discards all contents on a branch/jump/jr redirect.
- Circular FIFO of DEPTH entries with occupancy count and misalignment detection.

---
 rtl/fetch_queue.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, instruction} pairs with flush and misalignment flag.
// Optional same-cycle bypass on an empty queue is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_ins,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [31:0]   pop_pc,
    output logic [31:0]   pop_ins,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          align_err
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO_C = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE_C  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL_C = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO_C = AW'(1'b0);
    localparam logic [AW-1:0] PTR_ONE_C  = AW'(1'b1);

    logic [31:0]   mem_pc_r  [DEPTH];
    logic [31:0]   mem_ins_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          align_err_r;
    logic          push_ready_r;
    logic          pop_valid_r;
    logic [31:0]   pop_pc_r;
    logic [31:0]   pop_ins_r;

    logic          bypass_s;
    logic          push_fire_s;
    logic          pop_fire_s;
    logic          bypass_take_s;
    logic          store_s;
    logic          rd_adv_s;
    logic          misaligned_s;
    logic [AW-1:0] wr_ptr_nx_s;
    logic [AW-1:0] rd_ptr_nx_s;
    logic [CW-1:0] count_nx_s;
    logic [31:0]   head_pc_nx_s;
    logic [31:0]   head_ins_nx_s;

`ifdef FETCHQ_BYPASS_EN
    assign bypass_s   = (count_r == CNT_ZERO_C) && push_valid && !flush;
    assign pop_valid  = pop_valid_r | bypass_s;
    assign pop_pc     = bypass_s ? push_pc  : pop_pc_r;
    assign pop_ins    = bypass_s ? push_ins : pop_ins_r;
`else
    assign bypass_s   = 1'b0;
    assign pop_valid  = pop_valid_r;
    assign pop_pc     = pop_pc_r;
    assign pop_ins    = pop_ins_r;
`endif
    assign push_ready = push_ready_r;
    assign count      = count_r;
    assign align_err  = align_err_r;

    // A flushed cycle ignores both handshakes; a bypass-consumed entry never touches storage.
    assign push_fire_s   = push_valid && push_ready_r && !flush;
    assign pop_fire_s    = pop_valid && pop_ready && !flush;
    assign bypass_take_s = bypass_s && pop_ready;
    assign store_s       = push_fire_s && !bypass_take_s;
    assign rd_adv_s      = pop_fire_s && !bypass_take_s;
    assign misaligned_s  = (push_pc[1:0] != 2'b00);

    // Next pointer and occupancy state.
    always_comb begin
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
        count_nx_s  = count_r;
        if (flush) begin
            wr_ptr_nx_s = PTR_ZERO_C;
            rd_ptr_nx_s = PTR_ZERO_C;
            count_nx_s  = CNT_ZERO_C;
        end else begin
            if (store_s) begin
                wr_ptr_nx_s = wr_ptr_r + PTR_ONE_C;
            end else begin
                wr_ptr_nx_s = wr_ptr_r;
            end
            if (rd_adv_s) begin
                rd_ptr_nx_s = rd_ptr_r + PTR_ONE_C;
            end else begin
                rd_ptr_nx_s = rd_ptr_r;
            end
            case ({store_s, rd_adv_s})
                2'b10:   count_nx_s = count_r + CNT_ONE_C;
                2'b01:   count_nx_s = count_r - CNT_ONE_C;
                default: count_nx_s = count_r;
            endcase
        end
    end

    // Next head entry, forwarding this cycle's write when it lands at the new read slot.
    always_comb begin
        head_pc_nx_s  = 32'h0000_0000;
        head_ins_nx_s = 32'h0000_0000;
        if (count_nx_s == CNT_ZERO_C) begin
            head_pc_nx_s  = 32'h0000_0000;
            head_ins_nx_s = 32'h0000_0000;
        end else if (store_s && (wr_ptr_r == rd_ptr_nx_s)) begin
            head_pc_nx_s  = push_pc;
            head_ins_nx_s = push_ins;
        end else begin
            head_pc_nx_s  = mem_pc_r[rd_ptr_nx_s];
            head_ins_nx_s = mem_ins_r[rd_ptr_nx_s];
        end
    end

    // Entry storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_pc_r[wr_ptr_r]  <= push_pc;
            mem_ins_r[wr_ptr_r] <= push_ins;
        end
    end

    // Control state and registered handshake/head outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r     <= PTR_ZERO_C;
            rd_ptr_r     <= PTR_ZERO_C;
            count_r      <= CNT_ZERO_C;
            align_err_r  <= 1'b0;
            push_ready_r <= 1'b1;
            pop_valid_r  <= 1'b0;
            pop_pc_r     <= 32'h0000_0000;
            pop_ins_r    <= 32'h0000_0000;
        end else begin
            wr_ptr_r     <= wr_ptr_nx_s;
            rd_ptr_r     <= rd_ptr_nx_s;
            count_r      <= count_nx_s;
            push_ready_r <= (count_nx_s != CNT_FULL_C);
            pop_valid_r  <= (count_nx_s != CNT_ZERO_C);
            pop_pc_r     <= head_pc_nx_s;
            pop_ins_r    <= head_ins_nx_s;
            if (push_fire_s && misaligned_s) begin
                align_err_r <= 1'b1;
            end
        end
    end

endmodule
